// File: rtl/uart_mmio_port.sv
// Memory-mapped 8N1 UART: strobe-edge bus decode, 16x oversampled RX/TX FSMs,
// small TX/RX byte FIFOs and sticky overrun/framing flags.
module uart_mmio_port #(
    parameter int DVSR   = 41,
    parameter int FIFO_W = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic       tx,
    input  logic       rd,
    input  logic       wr,
    input  logic       s_io,
    input  logic       s_mmio,
    input  logic [7:0] data_in,
    output logic [7:0] data_out
);

    localparam int DEPTH = 2 ** FIFO_W;
    localparam int PW    = FIFO_W + 1;
    localparam int CW    = (DVSR > 1) ? $clog2(DVSR) : 1;

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } uart_state_t;

    // ------------------------------------------------------------------
    // Bus strobe edge detect and rx synchronizer
    // ------------------------------------------------------------------
    logic rd_q, wr_q;
    logic rx_meta, rx_sync;
    logic rd_acc, wr_acc;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_q    <= 1'b0;
            wr_q    <= 1'b0;
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
        end else begin
            rd_q    <= rd;
            wr_q    <= wr;
            rx_meta <= rx;
            rx_sync <= rx_meta;
        end
    end

    assign rd_acc = s_mmio & rd & ~rd_q;
    assign wr_acc = s_mmio & wr & ~wr_q;

    // ------------------------------------------------------------------
    // Oversampling tick: one pulse every DVSR clocks
    // ------------------------------------------------------------------
    logic [CW-1:0] tick_cnt;
    logic          tick;

    assign tick = (tick_cnt == CW'(DVSR - 1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)      tick_cnt <= '0;
        else if (tick) tick_cnt <= '0;
        else           tick_cnt <= tick_cnt + CW'(1);
    end

    // ------------------------------------------------------------------
    // TX FIFO
    // ------------------------------------------------------------------
    logic [7:0]  tx_mem [DEPTH];
    logic [PW-1:0] tx_wptr, tx_rptr;
    logic        tx_empty, tx_full, tx_push, tx_pop;
    logic [7:0]  tx_head;

    assign tx_empty = (tx_wptr == tx_rptr);
    assign tx_full  = (tx_wptr[FIFO_W] != tx_rptr[FIFO_W]) &&
                      (tx_wptr[FIFO_W-1:0] == tx_rptr[FIFO_W-1:0]);
    assign tx_head  = tx_mem[tx_rptr[FIFO_W-1:0]];
    // A push into a full FIFO is accepted when the FSM pops in the same clock.
    assign tx_push  = wr_acc & ~s_io & (~tx_full | tx_pop);

    // NOTE: FIFO storage has no reset; the pointers alone define which
    // entries are valid, so clearing the array would only cost logic.
    always_ff @(posedge clk) begin
        if (tx_push) tx_mem[tx_wptr[FIFO_W-1:0]] <= data_in;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tx_wptr <= '0;
            tx_rptr <= '0;
        end else begin
            if (tx_push) tx_wptr <= tx_wptr + PW'(1);
            if (tx_pop)  tx_rptr <= tx_rptr + PW'(1);
        end
    end

    // ------------------------------------------------------------------
    // TX FSM
    // ------------------------------------------------------------------
    uart_state_t tx_state, tx_state_n;
    logic [3:0]  tx_ticks, tx_ticks_n;
    logic [2:0]  tx_bits, tx_bits_n;
    logic [7:0]  tx_shift, tx_shift_n;
    logic        tx_q, tx_n;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tx_state <= IDLE;
            tx_ticks <= '0;
            tx_bits  <= '0;
            tx_shift <= '0;
            tx_q     <= 1'b1;
        end else begin
            tx_state <= tx_state_n;
            tx_ticks <= tx_ticks_n;
            tx_bits  <= tx_bits_n;
            tx_shift <= tx_shift_n;
            tx_q     <= tx_n;
        end
    end

    // NOTE: every output of this block gets a default first, so no path
    // through the case can leave a signal unassigned and infer a latch.
    always_comb begin
        tx_state_n = tx_state;
        tx_ticks_n = tx_ticks;
        tx_bits_n  = tx_bits;
        tx_shift_n = tx_shift;
        tx_n       = tx_q;
        tx_pop     = 1'b0;
        case (tx_state)
            IDLE: begin
                tx_n = 1'b1;
                if (!tx_empty) begin
                    tx_pop     = 1'b1;
                    tx_shift_n = tx_head;
                    tx_ticks_n = '0;
                    tx_n       = 1'b0;
                    tx_state_n = START;
                end
            end
            START: begin
                if (tick) begin
                    if (tx_ticks == 4'd15) begin
                        tx_ticks_n = '0;
                        tx_bits_n  = '0;
                        tx_n       = tx_shift[0];
                        tx_state_n = DATA;
                    end else begin
                        tx_ticks_n = tx_ticks + 4'd1;
                    end
                end
            end
            DATA: begin
                if (tick) begin
                    if (tx_ticks == 4'd15) begin
                        tx_ticks_n = '0;
                        tx_shift_n = {1'b0, tx_shift[7:1]};
                        if (tx_bits == 3'd7) begin
                            tx_n       = 1'b1;
                            tx_state_n = STOP;
                        end else begin
                            tx_bits_n = tx_bits + 3'd1;
                            tx_n      = tx_shift[1];
                        end
                    end else begin
                        tx_ticks_n = tx_ticks + 4'd1;
                    end
                end
            end
            STOP: begin
                if (tick) begin
                    if (tx_ticks == 4'd15) begin
                        // Chain straight into the next start bit when more data waits.
                        if (!tx_empty) begin
                            tx_pop     = 1'b1;
                            tx_shift_n = tx_head;
                            tx_ticks_n = '0;
                            tx_n       = 1'b0;
                            tx_state_n = START;
                        end else begin
                            tx_n       = 1'b1;
                            tx_state_n = IDLE;
                        end
                    end else begin
                        tx_ticks_n = tx_ticks + 4'd1;
                    end
                end
            end
            default: tx_state_n = IDLE;
        endcase
    end

    assign tx = tx_q;

    // ------------------------------------------------------------------
    // RX FSM
    // ------------------------------------------------------------------
    uart_state_t rx_state, rx_state_n;
    logic [3:0]  rx_ticks, rx_ticks_n;
    logic [2:0]  rx_bits, rx_bits_n;
    logic [7:0]  rx_shift, rx_shift_n;
    logic        rx_done, frame_set;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rx_state <= IDLE;
            rx_ticks <= '0;
            rx_bits  <= '0;
            rx_shift <= '0;
        end else begin
            rx_state <= rx_state_n;
            rx_ticks <= rx_ticks_n;
            rx_bits  <= rx_bits_n;
            rx_shift <= rx_shift_n;
        end
    end

    always_comb begin
        rx_state_n = rx_state;
        rx_ticks_n = rx_ticks;
        rx_bits_n  = rx_bits;
        rx_shift_n = rx_shift;
        rx_done    = 1'b0;
        frame_set  = 1'b0;
        case (rx_state)
            IDLE: begin
                if (!rx_sync) begin
                    rx_ticks_n = '0;
                    rx_state_n = START;
                end
            end
            START: begin
                if (tick) begin
                    if (rx_ticks == 4'd7) begin
                        // Mid start bit: a high line here was only a glitch.
                        if (rx_sync) begin
                            rx_state_n = IDLE;
                        end else begin
                            rx_ticks_n = '0;
                            rx_bits_n  = '0;
                            rx_state_n = DATA;
                        end
                    end else begin
                        rx_ticks_n = rx_ticks + 4'd1;
                    end
                end
            end
            DATA: begin
                if (tick) begin
                    if (rx_ticks == 4'd15) begin
                        rx_ticks_n = '0;
                        rx_shift_n = {rx_sync, rx_shift[7:1]};
                        if (rx_bits == 3'd7) rx_state_n = STOP;
                        else                 rx_bits_n  = rx_bits + 3'd1;
                    end else begin
                        rx_ticks_n = rx_ticks + 4'd1;
                    end
                end
            end
            STOP: begin
                if (tick) begin
                    if (rx_ticks == 4'd15) begin
                        rx_state_n = IDLE;
                        if (rx_sync) rx_done   = 1'b1;
                        else         frame_set = 1'b1;
                    end else begin
                        rx_ticks_n = rx_ticks + 4'd1;
                    end
                end
            end
            default: rx_state_n = IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // RX FIFO and sticky flags
    // ------------------------------------------------------------------
    logic [7:0]    rx_mem [DEPTH];
    logic [PW-1:0] rx_wptr, rx_rptr;
    logic          rx_empty, rx_full, rx_push, rx_pop;
    logic          overrun, frame_err, overrun_set, status_clr;

    assign rx_empty    = (rx_wptr == rx_rptr);
    assign rx_full     = (rx_wptr[FIFO_W] != rx_rptr[FIFO_W]) &&
                         (rx_wptr[FIFO_W-1:0] == rx_rptr[FIFO_W-1:0]);
    assign rx_pop      = rd_acc & ~s_io & ~rx_empty;
    assign rx_push     = rx_done & (~rx_full | rx_pop);
    assign overrun_set = rx_done & rx_full & ~rx_pop;
    assign status_clr  = rd_acc & s_io;

    always_ff @(posedge clk) begin
        if (rx_push) rx_mem[rx_wptr[FIFO_W-1:0]] <= rx_shift;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rx_wptr   <= '0;
            rx_rptr   <= '0;
            overrun   <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            if (rx_push) rx_wptr <= rx_wptr + PW'(1);
            if (rx_pop)  rx_rptr <= rx_rptr + PW'(1);
            // Set has priority over a status-read clear in the same clock.
            if (overrun_set)     overrun <= 1'b1;
            else if (status_clr) overrun <= 1'b0;
            if (frame_set)       frame_err <= 1'b1;
            else if (status_clr) frame_err <= 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // Read mux
    // ------------------------------------------------------------------
    always_comb begin
        data_out = 8'h00;
        if (s_io) begin
            data_out = {2'b00, frame_err, overrun, tx_full, tx_empty, rx_full, rx_empty};
        end else if (!rx_empty) begin
            data_out = rx_mem[rx_rptr[FIFO_W-1:0]];
        end
    end

endmodule

// File: tb/tb_uart_mmio_port.sv
// Self-checking bench for uart_mmio_port: directed tables, serial frame
// checks and a randomized sequence against a queue-based RX model.
module tb_uart_mmio_port;

    localparam int DVSR   = 4;
    localparam int FIFO_W = 2;
    localparam int DEPTH  = 2 ** FIFO_W;
    localparam int BIT    = 16 * DVSR;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       rx = 1'b1;
    logic       tx;
    logic       rd = 1'b0;
    logic       wr = 1'b0;
    logic       s_io = 1'b0;
    logic       s_mmio = 1'b0;
    logic [7:0] data_in = 8'h00;
    logic [7:0] data_out;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc;

    uart_mmio_port #(.DVSR(DVSR), .FIFO_W(FIFO_W)) dut (
        .clk(clk), .rst(rst), .rx(rx), .tx(tx), .rd(rd), .wr(wr),
        .s_io(s_io), .s_mmio(s_mmio), .data_in(data_in), .data_out(data_out)
    );

    always #5 clk = ~clk;

    // Clock count since reset release, used to start frames at a fixed tick phase.
    always @(posedge clk or negedge rst) begin
        if (!rst) cyc <= 0;
        else      cyc <= cyc + 1;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, %0d tests run", n_tests);
        $fatal(1);
    end

    // ---------------- checking helpers ----------------
    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %02h, expected %02h", name, act, exp);
        end
    endtask

    task automatic check_bit(input string name, input logic act, input logic exp);
        check(name, {7'b0, act}, {7'b0, exp});
    endtask

    // ---------------- bus helpers ----------------
    task automatic wait_clks(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic bus_read(input logic sio, output logic [7:0] val);
        @(negedge clk);
        s_mmio = 1'b1; s_io = sio; rd = 1'b1;
        #1 val = data_out;
        @(negedge clk);
        rd = 1'b0;
    endtask

    task automatic bus_write(input logic sio, input logic [7:0] d);
        @(negedge clk);
        s_mmio = 1'b1; s_io = sio; data_in = d; wr = 1'b1;
        @(negedge clk);
        wr = 1'b0;
    endtask

    task automatic peek(input logic sio, output logic [7:0] val);
        @(negedge clk);
        s_io = sio;
        #1 val = data_out;
    endtask

    // Drives one 8N1 frame. A bad stop bit is held low past the receiver's
    // mid-bit sample, then released so the line idles high again.
    task automatic send_byte(input logic [7:0] b, input bit stop_ok);
        @(negedge clk);
        while (cyc % DVSR != 0) @(negedge clk);
        rx = 1'b0;
        wait_clks(BIT);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            wait_clks(BIT);
        end
        if (stop_ok) begin
            rx = 1'b1;
            wait_clks(BIT + 16);
        end else begin
            rx = 1'b0;
            wait_clks(BIT * 5 / 8);
            rx = 1'b1;
            wait_clks(2 * BIT);
        end
    endtask

    // Waits for a start bit on tx and samples every bit near its centre.
    task automatic expect_serial(input logic [7:0] b, input string tag);
        bit seen = 0;
        for (int k = 0; k < 4 * BIT; k++) begin
            @(negedge clk);
            if (tx === 1'b0) begin
                seen = 1;
                break;
            end
        end
        check_bit({tag, "_start_seen"}, seen, 1'b1);
        if (!seen) return;
        wait_clks(BIT - 4);
        check_bit({tag, "_start_late"}, tx, 1'b0);
        wait_clks(36);
        check_bit({tag, "_bit0"}, tx, b[0]);
        for (int i = 1; i < 8; i++) begin
            wait_clks(BIT);
            check_bit($sformatf("%s_bit%0d", tag, i), tx, b[i]);
        end
        wait_clks(BIT);
        check_bit({tag, "_stop"}, tx, 1'b1);
    endtask

    task automatic count_tx_lows(input int n, output int lows);
        lows = 0;
        repeat (n) begin
            @(negedge clk);
            if (tx !== 1'b1) lows++;
        end
    endtask

    // ---------------- directed vector tables ----------------
    typedef struct {
        int         phase;  // which scenario the row belongs to
        bit         access; // 1 = strobed read, 0 = combinational peek
        logic       sio;
        logic [7:0] exp;
        string      name;
    } vec_t;

    vec_t vecs[$];

    task automatic add_vec(input int phase, input bit access, input logic sio,
                           input logic [7:0] exp, input string name);
        vec_t t;
        t.phase = phase; t.access = access; t.sio = sio; t.exp = exp; t.name = name;
        vecs.push_back(t);
    endtask

    task automatic run_vecs(input int phase);
        logic [7:0] got;
        foreach (vecs[i]) begin
            if (vecs[i].phase == phase) begin
                if (vecs[i].access) bus_read(vecs[i].sio, got);
                else                peek(vecs[i].sio, got);
                check(vecs[i].name, got, vecs[i].exp);
            end
        end
    endtask

    // ---------------- reference model for the random phase ----------------
    logic [7:0] rxq[$];
    bit         m_ov, m_fe;

    function automatic logic [7:0] m_status();
        return {2'b00, m_fe, m_ov, 1'b0, 1'b1, rxq.size() == DEPTH, rxq.size() == 0};
    endfunction

    function automatic logic [7:0] m_head();
        return (rxq.size() != 0) ? rxq[0] : 8'h00;
    endfunction

    // ---------------- main sequence ----------------
    logic [7:0] v, pv, rb;
    int         lows, d_push;
    bit         ok;

    initial begin : main
        // overrun scenario: 01..05 received, no reads yet
        add_vec(0, 0, 1'b1, 8'h16, "ovr_status_peek");
        add_vec(0, 0, 1'b0, 8'h01, "ovr_head_peek");
        add_vec(0, 1, 1'b0, 8'h01, "ovr_read1");
        add_vec(0, 1, 1'b0, 8'h02, "ovr_read2");
        add_vec(0, 1, 1'b0, 8'h03, "ovr_read3");
        add_vec(0, 1, 1'b0, 8'h04, "ovr_read4");
        add_vec(0, 1, 1'b0, 8'h00, "ovr_read_empty");
        add_vec(0, 1, 1'b1, 8'h15, "ovr_status_read");
        add_vec(0, 0, 1'b1, 8'h05, "ovr_status_cleared");
        // framing scenario: 0x3C with a low stop bit
        add_vec(1, 0, 1'b1, 8'h25, "frm_status_peek");
        add_vec(1, 0, 1'b0, 8'h00, "frm_rx_empty_data");
        add_vec(1, 1, 1'b1, 8'h25, "frm_status_read");
        add_vec(1, 1, 1'b1, 8'h05, "frm_status_next");

        // ---- reset values ----
        wait_clks(4);
        rst = 1'b1;
        peek(1'b1, v);   check("reset_status", v, 8'h05);
        peek(1'b0, v);   check("reset_data", v, 8'h00);
        check_bit("reset_tx", tx, 1'b1);

        // ---- reset mid-frame ----
        bus_write(1'b0, 8'hC3);
        bus_write(1'b0, 8'h5A);
        rx = 1'b0;
        wait_clks(200);
        #2 rst = 1'b0;
        #1 check_bit("midframe_tx_async", tx, 1'b1);
        rx = 1'b1;
        wait_clks(3);
        rst = 1'b1;
        peek(1'b1, v);   check("midframe_status", v, 8'h05);
        peek(1'b0, v);   check("midframe_data", v, 8'h00);
        count_tx_lows(3 * BIT, lows);
        check("midframe_tx_idle", 8'(lows), 8'h00);

        // ---- transmit 0x55 ----
        fork
            begin
                bus_write(1'b0, 8'h55);
                s_io = 1'b1;
                #1 check_bit("tx_empty_before_pop", data_out[2], 1'b0);
                @(negedge clk);
                #1 check_bit("tx_empty_after_pop", data_out[2], 1'b1);
            end
            expect_serial(8'h55, "tx55");
        join

        // ---- held write strobe: exactly one byte ----
        fork
            begin
                @(negedge clk);
                s_mmio = 1'b1; s_io = 1'b0; data_in = 8'h11; wr = 1'b1;
                wait_clks(5);
                wr = 1'b0;
            end
            expect_serial(8'h11, "held");
        join
        count_tx_lows(11 * BIT, lows);
        check("held_single_frame", 8'(lows), 8'h00);

        // ---- receive 0xA3 ----
        send_byte(8'hA3, 1'b1);
        peek(1'b1, v);   check("rx_status_nonempty", v, 8'h04);
        bus_read(1'b0, v); check("rx_data_A3", v, 8'hA3);
        peek(1'b1, v);   check("rx_status_after_pop", v, 8'h05);

        // ---- overrun ----
        for (int i = 1; i <= 5; i++) send_byte(8'(i), 1'b1);
        run_vecs(0);

        // ---- framing error ----
        send_byte(8'h3C, 1'b0);
        run_vecs(1);

        // ---- push/pop on the same clock with the RX FIFO full ----
        // Find how many clocks after the start edge a byte lands in the FIFO.
        d_push = 0;
        fork
            send_byte(8'h99, 1'b1);
            begin
                @(negedge rx);
                for (int k = 1; k <= 12 * BIT; k++) begin
                    peek(1'b1, pv);
                    if (!pv[0]) begin
                        d_push = k;
                        break;
                    end
                end
            end
        join
        check_bit("calib_push_seen", d_push != 0, 1'b1);
        bus_read(1'b0, v); check("calib_data", v, 8'h99);
        for (int i = 0; i < DEPTH; i++) send_byte(8'h10 + 8'(i), 1'b1);
        peek(1'b1, v);   check("simul_full_before", v, 8'h06);
        fork
            send_byte(8'h14, 1'b1);
            begin
                @(negedge rx);
                if (d_push > 1) begin
                    wait_clks(d_push - 1);
                    s_mmio = 1'b1; s_io = 1'b0; rd = 1'b1;
                    #1 pv = data_out;
                    @(negedge clk);
                    rd = 1'b0;
                    check("simul_pop_data", pv, 8'h10);
                end
            end
        join
        peek(1'b1, v);   check("simul_full_no_overrun", v, 8'h06);
        for (int i = 1; i <= DEPTH; i++) begin
            bus_read(1'b0, v);
            check($sformatf("simul_drain%0d", i), v, 8'h10 + 8'(i));
        end
        bus_read(1'b1, v); check("simul_status_end", v, 8'h05);

        // ---- randomized sequence against the queue model ----
        rxq.delete();
        m_ov = 0;
        m_fe = 0;
        for (int it = 0; it < 30; it++) begin
            case ($urandom_range(0, 5))
                0, 1: begin
                    rb = 8'($urandom);
                    ok = ($urandom_range(0, 7) != 0);
                    send_byte(rb, ok);
                    if (!ok)                      m_fe = 1;
                    else if (rxq.size() == DEPTH) m_ov = 1;
                    else                          rxq.push_back(rb);
                    peek(1'b1, v);
                    check($sformatf("rnd%0d_status_after_frame", it), v, m_status());
                end
                2: begin
                    bus_read(1'b0, v);
                    check($sformatf("rnd%0d_read_data", it), v, m_head());
                    if (rxq.size() != 0) void'(rxq.pop_front());
                end
                3: begin
                    bus_read(1'b1, v);
                    check($sformatf("rnd%0d_read_status", it), v, m_status());
                    m_ov = 0;
                    m_fe = 0;
                end
                4: begin
                    @(negedge clk);
                    s_mmio = 1'b0; s_io = 1'b0; rd = 1'b1;
                    @(negedge clk);
                    rd = 1'b0;
                    bus_write(1'b1, 8'($urandom));
                    peek(1'b0, v);
                    check($sformatf("rnd%0d_ignored_head", it), v, m_head());
                    peek(1'b1, v);
                    check($sformatf("rnd%0d_ignored_status", it), v, m_status());
                end
                default: begin
                    @(negedge clk);
                    s_mmio = 1'b1; s_io = 1'b0; rd = 1'b1;
                    #1 v = data_out;
                    wait_clks(4);
                    rd = 1'b0;
                    check($sformatf("rnd%0d_held_read", it), v, m_head());
                    if (rxq.size() != 0) void'(rxq.pop_front());
                    peek(1'b0, v);
                    check($sformatf("rnd%0d_held_next", it), v, m_head());
                end
            endcase
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_mmio_port.md
Name: uart_mmio_port

Overview:
Memory-mapped 8N1 UART peripheral that sits directly downstream of the ARC datapath/memory bus in the system top. It decodes the bus-A select bits and the microcode rd/wr strobes, and buffers transmit and receive bytes in small FIFOs. It returns an 8-bit read value that the top-level MM/IO multiplexer zero-extends onto the datapath data bus.

Parameters:
DVSR, 41, baud tick divisor; one tick every DVSR clocks gives 16x oversampling (12.5 MHz core clock, 19200 baud)
FIFO_W, 2, FIFO address width; each FIFO holds 2**FIFO_W bytes

Ports:
clk  input  1  core clock (divided system clock)
rst  input  1  reset, asynchronous, active-low
rx  input  1  serial receive line, idle high
tx  output  1  serial transmit line, idle high
rd  input  1  microcode read strobe
wr  input  1  microcode write strobe
s_io  input  1  register select: 0 = data register, 1 = status register
s_mmio  input  1  peripheral space select; accesses are ignored when 0
data_in  input  8  write data from bus B
data_out  output  8  read data to the MM/IO multiplexer

Behaviour:
- Reset state (rst=0, asynchronous): tx=1, both FIFOs empty, sticky flags cleared, tick counter 0, RX and TX FSMs in IDLE.
- Strobe edge detect: rd and wr are registered. An access fires only on the first clock of an assertion (rd & ~rd_q, or wr & ~wr_q) while s_mmio=1. A multi-cycle strobe therefore produces exactly one access.
- data_out is combinational.
  - s_io=0: RX FIFO head, or 8'h00 when the RX FIFO is empty.
  - s_io=1: status = {2'b00, frame_err, overrun, tx_full, tx_empty, rx_full, rx_empty}.
  - Status after reset = 8'h05.
- Read access, s_io=0: pops the RX FIFO at the clock edge if it is not empty; otherwise there is no effect.
- Read access, s_io=1: clears overrun and frame_err at the clock edge.
- Write access, s_io=0: pushes data_in[7:0] into the TX FIFO if it is not full; a write to a full TX FIFO is silently dropped.
- Write access, s_io=1: ignored.
- Tick generator: counter runs 0..DVSR-1; tick=1 for one clock when the count equals DVSR-1; it wraps to 0.
- TX FSM: IDLE -> START -> DATA -> STOP -> IDLE.
  - IDLE: tx=1. When the TX FIFO is not empty, pop one byte into the shift register and enter START.
  - START: tx=0 for 16 ticks.
  - DATA: 8 bits, LSB first, 16 ticks each.
  - STOP: tx=1 for 16 ticks, then IDLE.
  - Back-to-back bytes follow with no extra idle bit.
- RX FSM: IDLE -> START -> DATA -> STOP -> IDLE.
  - IDLE: wait for rx=0.
  - START: after 7 ticks, re-sample. If rx=1, treat it as a glitch and return to IDLE; otherwise reset the tick count and enter DATA.
  - DATA: sample every 16 ticks (mid-bit), shift LSB first, 8 bits.
  - STOP: after 16 ticks, sample the stop bit.
    - rx=1: push the byte into the RX FIFO.
    - rx=0: discard the byte and set frame_err.
- rx is passed through a 2-flop synchronizer before use.
- RX FIFO full when a byte completes: the byte is dropped, overrun is set, and FIFO contents are unchanged.
- Simultaneous RX push and CPU pop in the same clock: both occur, occupancy is unchanged, and the FIFO stays valid even at full.
  - An RX push when full coinciding with a pop is accepted; it is not an overrun.
- Simultaneous TX FSM pop and CPU push: both occur, with the same rule as the RX FIFO.
- Sticky flag set and clear in the same clock: set wins.
- Pointers wrap modulo 2**FIFO_W. Full and empty are distinguished by an extra count bit.
- Reset mid-frame returns tx to 1 asynchronously and discards partial frames and all FIFO contents.

Test Plan:
- Reset value: assert rst=0 mid-operation, then release; s_mmio=1, s_io=1 -> data_out=8'h05, tx=1; s_io=0 -> data_out=8'h00.
- Transmit: DVSR=4, write 8'h55 -> tx low for 64 clocks (start bit), then bits 1,0,1,0,1,0,1,0 at 64 clocks each, then stop high. tx_empty=0 during the first pop and returns to 1 after the pop.
- Receive: drive 8'hA3 serially at 64 clocks/bit -> rx_empty=0 after the stop bit, data register reads 8'hA3, one rd pulse -> status 8'h05.
- Overrun: FIFO_W=2, receive 5 bytes 01..05 with no reads -> status shows rx_full=1 and overrun=1 (8'h16). Reads return 01,02,03,04; a status read clears overrun.
- Framing error: send 8'h3C with the stop bit driven low -> RX FIFO stays empty, status=8'h25; the next status read returns 8'h05.
- Held strobe and simultaneity: hold wr for 5 cycles with data_in=8'h11 -> exactly one byte is transmitted. Pop the RX FIFO on the same clock a byte completes with the FIFO full -> occupancy stays 4 and overrun stays 0.
